// File: rtl/ysyx_220066_clint_pkg.sv
// ysyx_220066_clint_pkg: register offsets, cause codes, FSM encoding and byte-merge helper for the CLINT
package ysyx_220066_clint_pkg;
    localparam logic [15:0] OFF_MSIP = 16'h0000;
    localparam logic [15:0] OFF_MTIMECMP = 16'h4000;
    localparam logic [15:0] OFF_MTIME = 16'hBFF8;
    localparam logic [63:0] CAUSE_SW = 64'h8000_0000_0000_0003;
    localparam logic [63:0] CAUSE_TIMER = 64'h8000_0000_0000_0007;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ = 2'd1,
        ST_WAIT = 2'd2
    } state_t;
    function automatic logic [63:0] merge_bytes(input logic [63:0] old, input logic [63:0] wdata,
                                                input logic [7:0] wmask);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[i*8+:8] = wmask[i] ? wdata[i*8+:8] : old[i*8+:8];
        return r;
    endfunction
endpackage

// File: rtl/ysyx_220066_clint_if.sv
// ysyx_220066_clint_if: request/response bus between the core and the CLINT register window
interface ysyx_220066_clint_if;
    logic req_valid;
    logic req_ready;
    logic req_wen;
    logic [15:0] req_addr;
    logic [63:0] req_wdata;
    logic [7:0] req_wmask;
    logic resp_valid;
    logic [63:0] resp_rdata;
    logic resp_err;
    modport master(
        output req_valid, req_wen, req_addr, req_wdata, req_wmask,
        input req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave(
        input req_valid, req_wen, req_addr, req_wdata, req_wmask,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/ysyx_220066_clint_timer.sv
// ysyx_220066_clint_timer: prescaler, mtime, mtimecmp with byte-masked writes and registered mtip compare
module ysyx_220066_clint_timer
    import ysyx_220066_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic rst,
    input logic mtime_we,
    input logic mtimecmp_we,
    input logic [63:0] wdata,
    input logic [7:0] wmask,
    output logic [63:0] mtime,
    output logic [63:0] mtimecmp,
    output logic mtip
);
    localparam logic [15:0] PSC_LAST = 16'(PRESCALE - 1);
    logic [15:0] psc;
    logic tick;
    assign tick = psc == PSC_LAST;
    // A bus write to mtime swallows a coinciding tick; the prescaler keeps running.
    always_ff @(posedge clk) begin
        if (rst) begin
            psc <= 16'd0;
            mtime <= 64'd0;
            mtimecmp <= '1;
            mtip <= 1'b0;
        end else begin
            psc <= tick ? 16'd0 : psc + 16'd1;
            mtime <= mtime_we ? merge_bytes(mtime, wdata, wmask) : tick ? mtime + 64'd1 : mtime;
            if (mtimecmp_we) mtimecmp <= merge_bytes(mtimecmp, wdata, wmask);
            mtip <= mtime >= mtimecmp;
        end
    end
endmodule

// File: rtl/ysyx_220066_clint.sv
// ysyx_220066_clint: bus decode, msip and interrupt request FSM around the machine timer
module ysyx_220066_clint
    import ysyx_220066_clint_pkg::*;
#(
    parameter int PRESCALE = 1
) (
    input logic clk,
    input logic rst,
    ysyx_220066_clint_if.slave bus,
    input logic irq_enable,
    output logic intr_req,
    output logic [63:0] intr_cause,
    input logic intr_taken,
    output logic mtip,
    output logic msip_o
);
    logic acc, wr, hit_msip, hit_cmp, hit_time, mapped, msip, src_live;
    logic [63:0] mtime, mtimecmp, rdata_mux;
    state_t state;
    assign acc = bus.req_valid & bus.req_ready;
    assign wr = acc & bus.req_wen;
    assign hit_msip = bus.req_addr == OFF_MSIP;
    assign hit_cmp = bus.req_addr == OFF_MTIMECMP;
    assign hit_time = bus.req_addr == OFF_MTIME;
    assign mapped = hit_msip | hit_cmp | hit_time;
    assign rdata_mux = hit_msip ? {63'd0, msip} : hit_cmp ? mtimecmp : hit_time ? mtime : 64'd0;
    assign msip_o = msip;
    ysyx_220066_clint_timer #(.PRESCALE(PRESCALE)) u_timer (
        .clk(clk),
        .rst(rst),
        .mtime_we(wr & hit_time),
        .mtimecmp_we(wr & hit_cmp),
        .wdata(bus.req_wdata),
        .wmask(bus.req_wmask),
        .mtime(mtime),
        .mtimecmp(mtimecmp),
        .mtip(mtip)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.req_ready <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_rdata <= 64'd0;
            bus.resp_err <= 1'b0;
            msip <= 1'b0;
        end else begin
            bus.req_ready <= 1'b1;
            bus.resp_valid <= acc;
            bus.resp_rdata <= (acc & ~bus.req_wen) ? rdata_mux : 64'd0;
            bus.resp_err <= acc & ~mapped;
            if (wr & hit_msip & bus.req_wmask[0]) msip <= bus.req_wdata[0];
        end
    end
    // While requesting, only the source that was latched as the cause keeps the request alive.
    assign src_live = (intr_cause == CAUSE_SW) ? msip : mtip;
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            intr_req <= 1'b0;
            intr_cause <= 64'd0;
        end else begin
            case (state)
                ST_IDLE: if (irq_enable & (msip | mtip)) begin
                    state <= ST_REQ;
                    intr_req <= 1'b1;
                    intr_cause <= msip ? CAUSE_SW : CAUSE_TIMER;
                end
                ST_REQ: if (intr_taken) begin
                    state <= ST_WAIT;
                    intr_req <= 1'b0;
                end else if (~irq_enable | ~src_live) begin
                    state <= ST_IDLE;
                    intr_req <= 1'b0;
                end
                ST_WAIT: if (~irq_enable) state <= ST_IDLE;
                default: begin
                    state <= ST_IDLE;
                    intr_req <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: doc/ysyx_220066_clint.md
# ysyx_220066_clint

Core-local interruptor for the ysyx_220066 core. It holds the machine timer (`mtime`), the compare register (`mtimecmp`) and the software-interrupt bit (`msip`), all reachable through a memory-mapped request/response port. It drives the trap-raising side of the core's CSR unit: it asserts an interrupt request with the mcause value and holds it until the core reports that the trap was taken.

## Interface
Parameters:
- `PRESCALE`, default 1: `mtime` increments once every `PRESCALE` clk cycles. Legal range 1..65535.

Ports:
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  1  bus request valid.
- `req_ready`  out  1  bus request accepted this cycle.
- `req_wen`  in  1  1 = write, 0 = read.
- `req_addr`  in  16  byte offset within the CLINT window.
- `req_wdata`  in  64  write data.
- `req_wmask`  in  8  byte-lane write strobes.
- `resp_valid`  out  1  response valid; one-cycle pulse.
- `resp_rdata`  out  64  read data.
- `resp_err`  out  1  unmapped offset.
- `irq_enable`  in  1  global enable; the core drives it from mstatus.MIE (bit 3).
- `intr_req`  out  1  interrupt request toward the core's trap path.
- `intr_cause`  out  64  mcause value for the pending interrupt.
- `intr_taken`  in  1  pulse from the core in the cycle its CSR unit latches the trap.
- `mtip`  out  1  raw timer-pending status.
- `msip_o`  out  1  raw software-pending status.

## Operation
- Register map (64-bit aligned offsets):
  - 0x0000 `msip`: bit 0 is read/write; all other bits read 0.
  - 0x4000 `mtimecmp`.
  - 0xBFF8 `mtime`.
  - Any other offset: a read returns 0; a write is dropped. Both set `resp_err`=1.
- Writes honour `req_wmask` per byte. A write with `req_wmask`=0 is accepted and has no effect.
- Prescaler: a 16-bit counter runs 0..`PRESCALE`-1. `mtime` increments when the counter wraps to 0. When `PRESCALE`=1, `mtime` increments every cycle.
- `mtime` wraps from 0xFFFF_FFFF_FFFF_FFFF to 0 without any flag.
- If a bus write to `mtime` and an increment fall in the same cycle, the written value wins. The increment is lost and the prescaler is not reset.
- `mtip` is registered: (`mtime` >= `mtimecmp`), unsigned, evaluated from the register values at the start of the cycle.
- Interrupt FSM states:
  - IDLE: if `irq_enable` and (`msip` or `mtip`), go to REQ and latch the cause.
  - REQ: `intr_req`=1 and `intr_cause` is held stable. On `intr_taken`, go to WAIT. If the source clears or `irq_enable` drops before `intr_taken`, return to IDLE.
  - WAIT: `intr_req`=0. Return to IDLE when `irq_enable` is 0, so each trap entry (MIE cleared by the CSR unit) rearms exactly once.
- Cause encoding: software = 0x8000_0000_0000_0003; timer = 0x8000_0000_0000_0007. Software has priority when both sources are pending.
- Sources are levels. Software clears its source by writing `msip`=0 or raising `mtimecmp`.

## Timing
- `req_ready` is 1 in every cycle except reset, so a request is accepted in the same cycle it is presented.
- `resp_valid` and data follow exactly one cycle after acceptance. Back-to-back requests are legal, with one response per cycle.
- Read-after-write to the same register in consecutive cycles returns the new value.
- `mtip` reflects a `mtimecmp` or `mtime` write one cycle after that write's response cycle.
- `intr_req` rises one cycle after the qualifying condition becomes true in IDLE.
- `intr_req` falls in the cycle after `intr_taken`.
- `intr_taken` while not in REQ is ignored.
- Reset values:
  - `mtime`=0, prescaler=0, `mtimecmp`=all-ones, `msip`=0.
  - `mtip`=0, FSM=IDLE, `intr_req`=0, `intr_cause`=0.
  - `resp_valid`=0, `resp_rdata`=0, `resp_err`=0, `req_ready`=0.
- A reset in any cycle, including mid-request or in REQ, discards the pending response and returns every output to its reset value on the next edge.

## Structure
- Shared package constants: the three offsets, the two cause codes, and the FSM state encoding (IDLE/REQ/WAIT).
- One natural sub-module, `ysyx_220066_clint_timer`, containing the prescaler, `mtime`, `mtimecmp`, the masked-write merge and the `mtip` compare.
- The top level holds the bus decode, `msip` and the interrupt FSM.

## Test plan
- Reset, then read 0x4000 and 0xBFF8: expect 0xFFFF_FFFF_FFFF_FFFF and a small count, with `resp_err`=0.
- `PRESCALE`=4: sample `mtime` across 40 cycles; expect an increment of 10 ±1.
- Write `mtimecmp`=20 with `irq_enable`=1 and `PRESCALE`=1:
  - `intr_req` rises with cause 0x8000_0000_0000_0007 once `mtime` reaches 20.
  - Pulse `intr_taken`: `intr_req` drops the next cycle.
  - It re-asserts only after `irq_enable` toggles 0→1.
- Write `msip`=1 while the timer is also pending: expect cause 0x8000_0000_0000_0003. Write `msip`=0 before `intr_taken`: expect a return to IDLE, then a timer request.
- Write `mtime`=0xFFFF_FFFF_FFFF_FFFE with `wmask`=0xFF and `PRESCALE`=1: expect a read of 0x0 three cycles later.
- Read offset 0x0008: expect `resp_err`=1 and data 0. Assert `rst` in the middle of REQ: all outputs return to their reset values.
